bram_access_arbiter: RTL
========================

Name: bram_access_arbiter

Overview:
- Shares one single-port BRAM between a read requester and a write requester.
- Grants whole bursts of up to MAX_BURST beats to one side, then inserts TURN_CYCLES dead cycles before the next grant.
- Drives separate chip selects: bram_cs_rd for read windows, bram_cs_wr for write windows.
- Sits between the read/write client logic and the BRAM port; this replaces hand-sequenced chip-select timing.

Parameters:
- ADDR_W, 10, BRAM address width
- DATA_W, 32, BRAM data width
- MAX_BURST, 10, maximum beats per grant (legal range >= 1)
- TURN_CYCLES, 10, dead cycles between bursts (0 legal)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active low
- rd_req  in  1  read requester wants a beat; rd_addr valid while high
- rd_addr  in  ADDR_W  read address
- rd_gnt  out  1  read beat accepted this cycle
- rd_valid  out  1  rd_data valid; one cycle after an accepted read beat
- rd_data  out  DATA_W  read data (bram_rdata passthrough)
- wr_req  in  1  write requester wants a beat; wr_addr and wr_data valid while high
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_gnt  out  1  write beat accepted this cycle
- bram_cs_rd  out  1  BRAM chip select, read window
- bram_cs_wr  out  1  BRAM chip select, write window
- bram_we  out  1  BRAM write enable
- bram_addr  out  ADDR_W  BRAM address
- bram_wdata  out  DATA_W  BRAM write data
- bram_rdata  in  DATA_W  BRAM read data, 1-cycle latency

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values:
  - state = IDLE; beat_cnt = 0; turn_cnt = 0; last_served = WR.
  - rd_valid = 0.
  - All combinational outputs evaluate to 0 in IDLE.
- States: IDLE, RD_BURST, WR_BURST, TURN.
- IDLE transitions:
  - Only rd_req high -> RD_BURST.
  - Only wr_req high -> WR_BURST.
  - Both high -> the side not equal to last_served. After reset, read wins first.
  - Neither high -> stay in IDLE.
  - IDLE issues no beat. The first beat occurs in the first burst cycle.
- RD_BURST:
  - rd_gnt = rd_req. bram_cs_rd = rd_req. bram_we = 0. bram_addr = rd_addr.
  - Each cycle with rd_gnt: beat_cnt increments.
  - Exit to TURN when a beat occurs with beat_cnt == MAX_BURST-1, or when rd_req is low.
  - On exit: last_served <= RD; beat_cnt <= 0.
- WR_BURST: mirrors RD_BURST.
  - wr_gnt = wr_req. bram_cs_wr = wr_req. bram_we = wr_req.
  - bram_addr = wr_addr. bram_wdata = wr_data.
  - On exit: last_served <= WR.
- TURN:
  - Both chip selects low; both grants low.
  - turn_cnt counts 0..TURN_CYCLES-1, then -> IDLE.
  - TURN_CYCLES == 0: burst exit goes directly to IDLE.
- Grant and BRAM outputs are combinational from the state register and the request inputs. There is no added latency on the request side.
- Read return:
  - rd_valid is registered: rd_valid <= rd_gnt.
  - rd_data = bram_rdata, unregistered.
- bram_wdata = 0 and bram_addr = 0 outside the active burst state.
- Counter widths: beat_cnt is clog2(MAX_BURST+1) bits; turn_cnt is clog2(TURN_CYCLES+1) bits, minimum 1 bit.
- The opposite requester is never granted mid-burst, even if the active requester idles. A request drop ends the burst.
- The requester must hold addr/data stable while req is high and gnt is low.
- Reset mid-burst:
  - Returns to IDLE next cycle.
  - rd_valid = 0 on the cycle after reset is sampled; the pending read is discarded.
  - The write in flight is not retried.
- Requests arriving during TURN wait; they are not queued beyond the level of req.

Decomposition:
- Shared package bram_arb_pkg holds:
  - state enum (IDLE=2'b00, RD_BURST=2'b01, TURN=2'b10, WR_BURST=2'b11);
  - side enum (RD/WR) for last_served.
- One natural sub-module: bram_arb_turn_timer, the TURN dead-cycle counter with a done pulse. Everything else stays in the top.

Test Plan:
- Reset, then rd_req held high, MAX_BURST=10, TURN_CYCLES=10 -> rd_gnt high 10 consecutive cycles; rd_valid in the 10 following cycles; 10 cycles with both cs low; next read burst starts one IDLE cycle later.
- rd_req and wr_req both held high -> bursts alternate RD, WR, RD. bram_we is high exactly during WR bursts. Address 0x3FF is written with 0xDEADBEEF and read back on the next RD burst.
- rd_req high for 3 cycles then low -> 3 beats, TURN entered the cycle after the drop. A wr_req raised during TURN is granted after TURN plus IDLE.
- TURN_CYCLES=0, both requests continuous -> RD burst, IDLE, WR burst, with no dead cycles besides IDLE.
- rst_n low on the 5th beat of a read burst -> state IDLE next cycle; rd_valid low; last_served=WR, so a subsequent simultaneous request grants read first.
- wr_req toggling 1,0 while in RD_BURST with rd_req high -> wr_gnt stays 0 and bram_cs_wr stays 0 throughout the read burst.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// -----------------------------------------------------------------------------
// bram_arb_pkg
// Shared types and helpers for the BRAM access arbiter.
//   arb_state_t : arbiter FSM state encoding
//   arb_side_t  : which requester owned the most recent burst
//   cnt_width() : bit width needed to hold a count of 0..n (minimum 1 bit)
// -----------------------------------------------------------------------------
package bram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RD_BURST = 2'b01,
        TURN     = 2'b10,
        WR_BURST = 2'b11
    } arb_state_t;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } arb_side_t;

    // Width of a counter that must represent every value from 0 to n.
    function automatic int cnt_width(input int n);
        if (n < 1) begin
            return 1;
        end else begin
            return $clog2(n + 1);
        end
    endfunction

endpackage

// File: rtl/bram_arb_turn_timer.sv
// -----------------------------------------------------------------------------
// bram_arb_turn_timer
// Dead-cycle counter used while the arbiter sits in TURN. It counts
// 0..TURN_CYCLES-1 while active and raises done on the final dead cycle,
// then rearms to 0 for the next turnaround.
// Ports:
//   clk    in  system clock
//   rst_n  in  synchronous reset, active low
//   active in  arbiter is in the TURN state
//   done   out last dead cycle of the turnaround (combinational)
// -----------------------------------------------------------------------------
module bram_arb_turn_timer
    import bram_arb_pkg::*;
#(
    parameter int TURN_CYCLES = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    output logic done
);

    localparam int TURN_W = cnt_width(TURN_CYCLES);
    // With no dead cycles the arbiter never enters TURN; the guard only keeps
    // the terminal value well defined.
    localparam int TURN_LAST_I = (TURN_CYCLES > 0) ? (TURN_CYCLES - 1) : 0;
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_LAST_I);
    localparam logic [TURN_W-1:0] TURN_ONE  = TURN_W'(1);
    localparam logic [TURN_W-1:0] TURN_ZERO = TURN_W'(0);

    logic [TURN_W-1:0] turn_cnt_r;
    logic              done_s;

    assign done_s = active && (turn_cnt_r == TURN_LAST);
    assign done   = done_s;

    // Dead-cycle counter: advances while active, rearms on the final cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            turn_cnt_r <= TURN_ZERO;
        end else if (done_s) begin
            turn_cnt_r <= TURN_ZERO;
        end else if (active) begin
            turn_cnt_r <= turn_cnt_r + TURN_ONE;
        end
    end

endmodule

// File: rtl/bram_access_arbiter.sv
// -----------------------------------------------------------------------------
// bram_access_arbiter
// Shares one single-port BRAM between a read requester and a write requester.
// A grant covers a whole burst of up to MAX_BURST beats; a burst ends after
// the last beat or as soon as the owning request drops. TURN_CYCLES dead
// cycles with both chip selects low follow every burst, then one IDLE cycle
// picks the next owner. When both sides wait, the side that did not own the
// previous burst wins.
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   rd_req/rd_addr      read requester; rd_gnt marks an accepted beat
//   rd_valid/rd_data    read return, one cycle after an accepted beat
//   wr_req/wr_addr/...  write requester; wr_gnt marks an accepted beat
//   bram_cs_rd/_wr      chip selects for read and write windows
//   bram_we/addr/wdata  BRAM command port
//   bram_rdata          BRAM read data, 1-cycle latency
// Grants and BRAM command signals are combinational from the state register
// and the live request, so a beat is accepted in the same cycle it is asked.
// -----------------------------------------------------------------------------
module bram_access_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int MAX_BURST   = 10,
    parameter int TURN_CYCLES = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic              bram_cs_rd,
    output logic              bram_cs_wr,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata
);

    localparam int BEAT_W = cnt_width(MAX_BURST);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
    localparam logic [BEAT_W-1:0] BEAT_ZERO = BEAT_W'(0);
    // Without dead cycles a finished burst falls straight back to IDLE.
    localparam arb_state_t EXIT_STATE = (TURN_CYCLES == 0) ? IDLE : TURN;

    arb_state_t        state_r;
    arb_side_t         last_served_r;
    logic [BEAT_W-1:0] beat_cnt_r;
    logic              rd_valid_r;

    logic              rd_gnt_s;
    logic              wr_gnt_s;
    logic              cs_rd_s;
    logic              cs_wr_s;
    logic              we_s;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] wdata_s;
    logic              active_req_s;
    logic              burst_end_s;
    logic              turn_active_s;
    logic              turn_done_s;

    assign turn_active_s = (state_r == TURN);

    bram_arb_turn_timer #(
        .TURN_CYCLES (TURN_CYCLES)
    ) u_turn_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .active (turn_active_s),
        .done   (turn_done_s)
    );

    // Grant and BRAM command decode for the current window.
    always_comb begin
        rd_gnt_s     = 1'b0;
        wr_gnt_s     = 1'b0;
        cs_rd_s      = 1'b0;
        cs_wr_s      = 1'b0;
        we_s         = 1'b0;
        addr_s       = {ADDR_W{1'b0}};
        wdata_s      = {DATA_W{1'b0}};
        active_req_s = 1'b0;
        case (state_r)
            RD_BURST: begin
                rd_gnt_s     = rd_req;
                cs_rd_s      = rd_req;
                addr_s       = rd_addr;
                active_req_s = rd_req;
            end
            WR_BURST: begin
                wr_gnt_s     = wr_req;
                cs_wr_s      = wr_req;
                we_s         = wr_req;
                addr_s       = wr_addr;
                wdata_s      = wr_data;
                active_req_s = wr_req;
            end
            default: begin
                active_req_s = 1'b0;
            end
        endcase
    end

    // A burst closes on its last beat or when the owner stops requesting.
    assign burst_end_s = !active_req_s || (beat_cnt_r == BEAT_LAST);

    // Arbiter FSM, beat counter, fairness memory and read-valid register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            beat_cnt_r    <= BEAT_ZERO;
            last_served_r <= WR;
            rd_valid_r    <= 1'b0;
        end else begin
            rd_valid_r <= rd_gnt_s;
            case (state_r)
                IDLE: begin
                    if (rd_req && wr_req) begin
                        state_r <= (last_served_r == RD) ? WR_BURST : RD_BURST;
                    end else if (rd_req) begin
                        state_r <= RD_BURST;
                    end else if (wr_req) begin
                        state_r <= WR_BURST;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD_BURST, WR_BURST: begin
                    if (burst_end_s) begin
                        state_r       <= EXIT_STATE;
                        beat_cnt_r    <= BEAT_ZERO;
                        last_served_r <= (state_r == RD_BURST) ? RD : WR;
                    end else begin
                        beat_cnt_r <= beat_cnt_r + BEAT_ONE;
                    end
                end
                TURN: begin
                    if (turn_done_s) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign rd_gnt     = rd_gnt_s;
    assign wr_gnt     = wr_gnt_s;
    assign bram_cs_rd = cs_rd_s;
    assign bram_cs_wr = cs_wr_s;
    assign bram_we    = we_s;
    assign bram_addr  = addr_s;
    assign bram_wdata = wdata_s;
    assign rd_valid   = rd_valid_r;
    // Read data comes straight from the BRAM; rd_valid qualifies it.
    assign rd_data    = bram_rdata;

endmodule
